// File: rtl/debounce_multi.sv
// Multi-channel button conditioner: 2-flop sync, tick-rate history sampling, level/press/release.
// Define DEBOUNCE_AUTOREPEAT_EN to add auto-repeat press pulses while a button is held.
module debounce_multi #(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 131072,
  parameter int HIST         = 3,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic            tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // state       | meaning
  // S_RELEASED  | accepted level 0
  // S_HOLD_WAIT | accepted level 1, waiting out the first repeat delay
  // S_REPEATING | accepted level 1, issuing repeats at the repeat rate
  typedef enum logic [1:0] {S_RELEASED, S_HOLD_WAIT, S_REPEATING} state_t;

  logic [CW-1:0]   r_cnt;
  logic            r_tick;
  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;
  // Only HIST-1 old samples are stored; the current synchronised bit completes the window.
  logic [HIST-2:0] r_hist      [N_CH];
  state_t          r_state     [N_CH];
  state_t          w_state_nxt [N_CH];
  logic [HIST-1:0] w_hist_nxt  [N_CH];
  logic [N_CH-1:0] w_press_nxt;
  logic [N_CH-1:0] w_rel_nxt;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] r_rep     [N_CH];
  logic [RW-1:0] w_rep_nxt [N_CH];
`else
  logic w_unused_rep;
  assign w_unused_rep = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == CW'(TICK_DIV - 1));
      r_cnt  <= (r_cnt == CW'(TICK_DIV - 1)) ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick_o = r_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      for (int c = 0; c < N_CH; c++) r_hist[c] <= '0;
    end else begin
      r_sync1 <= btn_i;
      r_sync2 <= r_sync1;
      if (r_tick) begin
        for (int c = 0; c < N_CH; c++) r_hist[c] <= w_hist_nxt[c][HIST-2:0];
      end
    end
  end

  always_comb begin
    w_press_nxt = '0;
    w_rel_nxt   = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_hist_nxt[c]  = {r_hist[c], r_sync2[c]};
      w_state_nxt[c] = r_state[c];
`ifdef DEBOUNCE_AUTOREPEAT_EN
      w_rep_nxt[c]   = r_rep[c];
`endif
      if (r_tick) begin
        case (r_state[c])
          S_RELEASED: begin
            if (&w_hist_nxt[c]) begin
              w_state_nxt[c] = S_HOLD_WAIT;
              w_press_nxt[c] = 1'b1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
              w_rep_nxt[c]   = RW'(REPEAT_DELAY);
`endif
            end
          end
          default: begin
            // A release on the same tick as a due repeat wins; no repeat is issued.
            if (~|w_hist_nxt[c]) begin
              w_state_nxt[c] = S_RELEASED;
              w_rel_nxt[c]   = 1'b1;
            end
`ifdef DEBOUNCE_AUTOREPEAT_EN
            else if (r_rep[c] == RW'(1)) begin
              w_state_nxt[c] = S_REPEATING;
              w_press_nxt[c] = 1'b1;
              w_rep_nxt[c]   = RW'(REPEAT_RATE);
            end else begin
              w_rep_nxt[c]   = r_rep[c] - 1'b1;
            end
`endif
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        r_state[c] <= S_RELEASED;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        r_rep[c]   <= '0;
`endif
      end
      press_o   <= '0;
      release_o <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        r_state[c] <= w_state_nxt[c];
`ifdef DEBOUNCE_AUTOREPEAT_EN
        r_rep[c]   <= w_rep_nxt[c];
`endif
      end
      press_o   <= w_press_nxt;
      release_o <= w_rel_nxt;
    end
  end

  always_comb begin
    level_o = '0;
    for (int c = 0; c < N_CH; c++) level_o[c] = (r_state[c] != S_RELEASED);
  end

endmodule
